// File: rtl/alu_pkg.sv
// Shared types and constants for the flag ALU: opcodes, controller states,
// flag bit positions and the flag-register select value.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned FZ = 0;
    localparam int unsigned FN = 1;
    localparam int unsigned FC = 2;
    localparam int unsigned FV = 3;

    localparam logic [2:0] FULL_LOAD = 3'b100;

endpackage

// File: rtl/shift_add_mul.sv
// 8x8 unsigned iterative multiplier datapath: one shift-add step per enabled
// cycle; product_next exposes the accumulator value after the current step.
module shift_add_mul (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [2:0]  count,
    output logic [15:0] product_next
);

    logic [15:0] acc;
    logic [7:0]  mcand;
    logic [7:0]  mplr;

    // Multiplicand is shifted by the step count rather than shifting the
    // accumulator, so the full product is visible combinationally on step 8.
    always_comb begin
        product_next = acc;
        if (mplr[0]) begin
            product_next = acc + ({8'h00, mcand} << count);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            count <= '0;
        end else if (load) begin
            acc   <= '0;
            mcand <= a;
            mplr  <= b;
            count <= '0;
        end else if (step) begin
            acc   <= product_next;
            mplr  <= mplr >> 1;
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/flag_alu.sv
// Flag-producing ALU: single-cycle logic/arithmetic ops plus an 8-step
// shift-add multiply, with a registered result and ZNCV flag vector.
module flag_alu
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y,
    output logic       busy,
    output logic       done,
    output logic [7:0] f,
    output logic [2:0] s
);

    state_e      state;
    state_e      state_next;
    logic        mul_load;
    logic        mul_step;
    logic        capture;
    logic [7:0]  res;
    logic        carry;
    logic        ovf;
    logic [8:0]  sum9;
    logic [7:0]  flags;
    logic [2:0]  mul_count;
    logic [15:0] mul_product;

    shift_add_mul u_mul (
        .clk          (clk),
        .reset        (reset),
        .load         (mul_load),
        .step         (mul_step),
        .a            (a),
        .b            (b),
        .count        (mul_count),
        .product_next (mul_product)
    );

    always_comb begin
        state_next = state;
        mul_load   = 1'b0;
        mul_step   = 1'b0;
        capture    = 1'b0;
        res        = '0;
        carry      = 1'b0;
        ovf        = 1'b0;
        sum9       = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op_e'(op) == OP_MUL) begin
                        mul_load   = 1'b1;
                        state_next = MULT;
                    end else begin
                        capture    = 1'b1;
                        state_next = DONE;
                        case (op_e'(op))
                            OP_ADD: begin
                                sum9  = {1'b0, a} + {1'b0, b};
                                res   = sum9[7:0];
                                carry = sum9[8];
                                ovf   = (a[7] == b[7]) && (res[7] != a[7]);
                            end
                            OP_SUB: begin
                                res   = a - b;
                                carry = (a < b);
                                ovf   = (a[7] != b[7]) && (res[7] != a[7]);
                            end
                            OP_AND: res = a & b;
                            OP_OR:  res = a | b;
                            OP_XOR: res = a ^ b;
                            OP_SHL: begin
                                res   = {a[6:0], 1'b0};
                                carry = a[7];
                                ovf   = a[7] ^ a[6];
                            end
                            OP_SHR: begin
                                res   = {1'b0, a[7:1]};
                                carry = a[0];
                            end
                            default: res = '0;
                        endcase
                    end
                end
            end
            MULT: begin
                mul_step = 1'b1;
                if (mul_count == 3'd7) begin
                    capture    = 1'b1;
                    state_next = DONE;
                    res        = mul_product[7:0];
                    carry      = |mul_product[15:8];
                    ovf        = |mul_product[15:8];
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        flags     = '0;
        flags[FZ] = (res == 8'h00);
        flags[FN] = res[7];
        flags[FC] = carry;
        flags[FV] = ovf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            y     <= '0;
            f     <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                y <= res;
                f <= flags;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign s    = FULL_LOAD;

endmodule
